// File: rtl/lsu_mem_stage_if.sv
// Bundles the EX-side handshake, the data-memory port and the writeback outputs of the load/store stage.
// The slave modport is the stage itself; the master modport is whatever drives it.
interface lsu_mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [3:0]  data_write_byte;
  logic [31:0] data_read;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr, ex_store_data, ex_rd,
    input  data_read,
    output ex_ready, data_addr, data_write, data_write_byte,
    output wb_valid, wb_reg_write, wb_rd, wb_data, wb_err
  );

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr, ex_store_data, ex_rd,
    output data_read,
    input  ex_ready, data_addr, data_write, data_write_byte,
    input  wb_valid, wb_reg_write, wb_rd, wb_data, wb_err
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I load/store unit: lane steering, load extraction and a two-state FSM that splits
// word-crossing accesses into two memory cycles, with registered writeback outputs.
module lsu_mem_stage #(
  parameter int DMEM_BYTES = 128,
  parameter bit SPLIT_EN   = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  lsu_mem_stage_if.slave bus
);
  typedef enum logic {S_IDLE, S_SECOND} state_t;

  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      2'b10:   size_of = 3'd4;
      default: size_of = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      3'd4:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // hi:lo is the pair of words the access touched; unsplit accesses pass hi = 0.
  function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] w;
    w = 32'({hi, lo} >> {off, 3'b000});
    case (f3)
      3'b000:  extract = {{24{w[7]}}, w[7:0]};
      3'b100:  extract = {24'h0, w[7:0]};
      3'b001:  extract = {{16{w[15]}}, w[15:0]};
      3'b101:  extract = {16'h0, w[15:0]};
      default: extract = w;
    endcase
  endfunction

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic [31:0] r_lo_buf;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_is_store;
  logic        r_wb_valid;
  logic        r_wb_reg_write;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_err;

  logic [2:0]  w_size;
  logic [1:0]  w_off;
  logic        w_f3_ok;
  logic [32:0] w_last;
  logic        w_oor;
  logic        w_split;
  logic        w_err;
  logic        w_xfer;
  logic [7:0]  w_lane;
  logic [2:0]  w_hi_shift;

  assign w_size  = size_of(bus.ex_funct3[1:0]);
  assign w_off   = bus.ex_addr[1:0];
  assign w_f3_ok = (bus.ex_funct3 == 3'b000) || (bus.ex_funct3 == 3'b001) ||
                   (bus.ex_funct3 == 3'b010) || (bus.ex_funct3 == 3'b100) ||
                   (bus.ex_funct3 == 3'b101);
  // Last byte computed in 33 bits so that a wrap past 2^32 lands in the error range.
  assign w_last  = {1'b0, bus.ex_addr} + 33'(w_size) - 33'd1;
  assign w_oor   = w_last[32] || (w_last[31:0] >= 32'(DMEM_BYTES));
  assign w_split = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_err   = !w_f3_ok || (bus.ex_mem_read && bus.ex_mem_write) ||
                   (!bus.ex_mem_read && !bus.ex_mem_write) || w_oor ||
                   (w_split && !SPLIT_EN);
  assign w_xfer  = bus.ex_valid && (r_state == S_IDLE);
  assign w_lane  = {4'h0, lane_mask(w_size)} << w_off;
  assign w_hi_shift = 3'd4 - {1'b0, r_addr[1:0]};

  always_comb begin
    bus.ex_ready        = (r_state == S_IDLE);
    bus.data_addr       = 32'h0;
    bus.data_write      = 32'h0;
    bus.data_write_byte = 4'h0;
    if (r_state == S_SECOND) begin
      bus.data_addr       = {r_addr[31:2], 2'b00} + 32'd4;
      bus.data_write      = r_store >> {w_hi_shift, 3'b000};
      bus.data_write_byte = r_is_store ? (lane_mask(size_of(r_funct3[1:0])) >> w_hi_shift) : 4'h0;
    end else if (w_xfer && !w_err) begin
      bus.data_addr       = {bus.ex_addr[31:2], 2'b00};
      bus.data_write      = bus.ex_store_data << {w_off, 3'b000};
      bus.data_write_byte = bus.ex_mem_write ? w_lane[3:0] : 4'h0;
    end
  end

  // Writeback register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_addr         <= 32'h0;
      r_store        <= 32'h0;
      r_lo_buf       <= 32'h0;
      r_funct3       <= 3'h0;
      r_rd           <= 5'h0;
      r_is_store     <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= 5'h0;
      r_wb_data      <= 32'h0;
      r_wb_err       <= 1'b0;
    end else begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (w_err) begin
              r_wb_valid <= 1'b1;
              r_wb_err   <= 1'b1;
              r_wb_rd    <= bus.ex_rd;
              r_wb_data  <= 32'h0;
            end else if (w_split) begin
              r_addr     <= bus.ex_addr;
              r_store    <= bus.ex_store_data;
              r_lo_buf   <= bus.data_read;
              r_funct3   <= bus.ex_funct3;
              r_rd       <= bus.ex_rd;
              r_is_store <= bus.ex_mem_write;
              r_state    <= S_SECOND;
            end else begin
              r_wb_valid     <= 1'b1;
              r_wb_err       <= 1'b0;
              r_wb_rd        <= bus.ex_rd;
              r_wb_data      <= bus.ex_mem_read ?
                                extract(32'h0, bus.data_read, w_off, bus.ex_funct3) : 32'h0;
              r_wb_reg_write <= bus.ex_mem_read && (bus.ex_rd != 5'd0);
            end
          end
        end
        S_SECOND: begin
          r_wb_valid     <= 1'b1;
          r_wb_err       <= 1'b0;
          r_wb_rd        <= r_rd;
          r_wb_data      <= r_is_store ? 32'h0 :
                            extract(bus.data_read, r_lo_buf, r_addr[1:0], r_funct3);
          r_wb_reg_write <= !r_is_store && (r_rd != 5'd0);
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_reg_write = r_wb_reg_write;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_data      = r_wb_data;
  assign bus.wb_err       = r_wb_err;
endmodule
